// File: rtl/out_unit_tx.sv
// out_unit_tx: buffers 32-bit words from the out-port register and serialises each one
//   as four LSB-first UART frames (start, 8 data, [parity], stop) on a registered tx line.
// Latency: load sampled at edge k, head popped at edge k+1, tx falls right after edge k+1.
// Backpressure: none upstream; a load into a full FIFO with no same-edge pop is dropped
//   and raises the sticky overflow flag.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles each serial bit is held (>= 2)
//   FIFO_DEPTH    number of 32-bit words buffered (power of two, >= 2)
// Ports:
//   Clock         system clock, rising edge
//   Clear         asynchronous active-low reset
//   data_in       word from the out-port register
//   load          one-cycle write strobe, data_in sampled on the same edge
//   overflow_clr  synchronous clear of the overflow flag (a same-edge drop wins)
//   tx            serial line, idles high
//   busy          transmitter active or FIFO non-empty
//   full          FIFO holds FIFO_DEPTH words
//   overflow      sticky flag, set when a load is dropped
// Build option:
//   OUT_UNIT_PARITY_EN  when defined, an even-parity bit is sent between the data bits
//                       and the stop bit (11-bit frames instead of 10-bit frames).

module out_unit_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 2
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] data_in,
  input  logic        load,
  input  logic        overflow_clr,
  output logic        tx,
  output logic        busy,
  output logic        full,
  output logic        overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] BIT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   DEPTH_C    = (PTR_W + 1)'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef OUT_UNIT_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [2:0]       state_q,    state_d;
  logic [CNT_W-1:0] bit_cnt_q,  bit_cnt_d;
  logic [2:0]       bit_idx_q,  bit_idx_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [31:0]      word_q,     word_d;
  logic             tx_q,       tx_d;

  logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [PTR_W:0]   count_q,    count_d;
  logic             ovf_q,      ovf_d;

  logic [31:0]      mem [FIFO_DEPTH];

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  logic        fifo_empty;
  logic        word_end;
  logic        pop;
  logic        push;
  logic        drop;
  logic [31:0] head;
  logic [7:0]  cur_byte;

  assign fifo_empty = (count_q == '0);
  assign full       = (count_q == DEPTH_C);
  assign busy       = (state_q != S_IDLE) || !fifo_empty;
  assign head       = mem[rd_ptr_q];
  assign cur_byte   = word_q[{byte_idx_q, 3'b000} +: 8];

  // Last cycle of the stop bit of byte 3: the next word may be fetched here so
  // that back-to-back words leave no idle bit time on the line.
  assign word_end = (state_q == S_STOP) && (bit_cnt_q == '0) && (byte_idx_q == 2'd3);

  assign pop  = !fifo_empty && ((state_q == S_IDLE) || word_end);
  // A pop on the same edge frees a slot, so a load into a full FIFO still lands.
  assign push = load && (!full || pop);
  assign drop = load && full && !pop;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (overflow_clr) begin
      ovf_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Serialiser FSM
  // ---------------------------------------------------------------------------
  // tx_d always carries the value of the bit that starts on this edge, so the
  // line changes exactly at bit boundaries and comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    tx_d       = tx_q;

    if (state_q == S_IDLE) begin
      tx_d = 1'b1;
      if (pop) begin
        state_d    = S_START;
        word_d     = head;
        byte_idx_d = 2'd0;
        bit_idx_d  = 3'd0;
        bit_cnt_d  = BIT_RELOAD;
        tx_d       = 1'b0;
      end
    end else if (bit_cnt_q != '0) begin
      bit_cnt_d = bit_cnt_q - CNT_W'(1);
    end else begin
      bit_cnt_d = BIT_RELOAD;
      case (state_q)
        S_START: begin
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
          tx_d      = cur_byte[0];
        end
        S_DATA: begin
          if (bit_idx_q != 3'd7) begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = cur_byte[bit_idx_q + 3'd1];
          end else begin
`ifdef OUT_UNIT_PARITY_EN
            state_d = S_PARITY;
            tx_d    = ^cur_byte;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end
        end
`ifdef OUT_UNIT_PARITY_EN
        S_PARITY: begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
`endif
        S_STOP: begin
          if (byte_idx_q != 2'd3) begin
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = S_START;
            tx_d       = 1'b0;
          end else if (pop) begin
            word_d     = head;
            byte_idx_d = 2'd0;
            state_d    = S_START;
            tx_d       = 1'b0;
          end else begin
            state_d    = S_IDLE;
            byte_idx_d = 2'd0;
            bit_cnt_d  = '0;
            tx_d       = 1'b1;
          end
        end
        default: begin
          // Unused encodings fall back to a clean idle line.
          state_d    = S_IDLE;
          bit_cnt_d  = '0;
          bit_idx_d  = 3'd0;
          byte_idx_d = 2'd0;
          tx_d       = 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 2'd0;
      word_q     <= 32'd0;
      tx_q       <= 1'b1;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      tx_q       <= tx_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage needs no reset: a zero count makes every entry invisible.
  always_ff @(posedge Clock) begin
    if (push) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  assign tx       = tx_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_out_unit_tx.sv
// Testbench for out_unit_tx: directed scenarios with literal expectations plus a
// randomized load/clear phase, all outputs compared every cycle against a
// word-level model (FIFO queue + position inside the current word).

module tb_out_unit_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 2;
`ifdef OUT_UNIT_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int WORD_CYC = 4 * FB * CPB;

  logic        Clock = 1'b0;
  logic        Clear = 1'b1;
  logic [31:0] data_in = 32'd0;
  logic        load = 1'b0;
  logic        overflow_clr = 1'b0;
  logic        tx;
  logic        busy;
  logic        full;
  logic        overflow;

  out_unit_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .Clock        (Clock),
    .Clear        (Clear),
    .data_in      (data_in),
    .load         (load),
    .overflow_clr (overflow_clr),
    .tx           (tx),
    .busy         (busy),
    .full         (full),
    .overflow     (overflow)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: queue of buffered words, plus the word on the line and the
  // cycle position inside it (0 .. WORD_CYC-1).
  // ---------------------------------------------------------------------------
  logic [31:0] mq[$];
  logic [31:0] sent[$];
  bit          m_act = 1'b0;
  int          m_pos = 0;
  logic [31:0] m_cur = 32'd0;
  bit          m_ovf = 1'b0;
  bit          m_fin, m_pop, m_drop;

  always @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      mq.delete();
      m_act = 1'b0;
      m_pos = 0;
      m_cur = 32'd0;
      m_ovf = 1'b0;
    end else begin
      m_fin  = m_act && (m_pos == WORD_CYC - 1);
      m_pop  = (mq.size() > 0) && (!m_act || m_fin);
      m_drop = load && (mq.size() == DEPTH) && !m_pop;
      if (m_pop) begin
        m_cur = mq.pop_front();
        sent.push_back(m_cur);
        m_act = 1'b1;
        m_pos = 0;
      end else if (m_fin) begin
        m_act = 1'b0;
        m_pos = 0;
      end else if (m_act) begin
        m_pos++;
      end
      if (load && !m_drop) mq.push_back(data_in);
      if (m_drop) m_ovf = 1'b1;
      else if (overflow_clr) m_ovf = 1'b0;
    end
  end

  function automatic logic exp_tx();
    int b, f, w;
    logic [7:0] by;
    if (!m_act) return 1'b1;
    b  = m_pos / CPB;
    f  = b / FB;
    w  = b % FB;
    by = m_cur[f*8 +: 8];
    if (w == 0) return 1'b0;
    if (w <= 8) return by[w-1];
    if (FB == 11 && w == 9) return ^by;
    return 1'b1;
  endfunction

  bit cmp_en = 1'b0;

  always @(negedge Clock) begin
    if (cmp_en && Clear) begin
      chk("model_tx", tx, exp_tx());
      chk("model_busy", busy, (m_act || mq.size() > 0));
      chk("model_full", full, (mq.size() == DEPTH));
      chk("model_overflow", overflow, m_ovf);
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(negedge Clock);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((busy || m_act || mq.size() != 0) && n < limit) begin
      step();
      n++;
    end
    chk("idle_wait_in_budget", (n < limit), 1);
  endtask

  // Load one word from idle, check the start latency, every bit of frame 0
  // against a literal bit list (index 0 = start bit), and when busy falls.
  task automatic check_first_frame(input logic [31:0] w, input logic [10:0] exp, input int nb);
    int n;
    step();
    load = 1'b1; data_in = w;
    step();                                   // edge k: word written
    load = 1'b0;
    chk("lat_k_tx", tx, 1);
    chk("lat_k_busy", busy, 1);
    step();                                   // edge k+1: pop, start bit
    chk("lat_k1_tx", tx, 0);
    n = 0;
    for (int c = 0; c < nb * CPB; c++) begin
      if (c % CPB == CPB / 2) chk("frame0_bit", tx, exp[c / CPB]);
      step();
      n++;
    end
    while (busy && n < WORD_CYC + 50) begin
      step();
      n++;
    end
    chk("busy_fall_after_pop", n, WORD_CYC);
    chk("idle_tx_high", tx, 1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int idx;
    int n;
    bit seen_bad;
    logic [31:0] w;

    #1 Clear = 1'b0;
    #1;
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_full", full, 0);
    chk("reset_overflow", overflow, 0);
    repeat (3) step();
    #2 Clear = 1'b1;
    step();
    cmp_en = 1'b1;

    // Single word 0xA5: 0,1,0,1,0,0,1,0,1,(parity 0,)1
`ifdef OUT_UNIT_PARITY_EN
    check_first_frame(32'h0000_00A5, 11'b101_0100_1010, 11);
    check_first_frame(32'h0000_0001, 11'b110_0000_0010, 11);
`else
    check_first_frame(32'h0000_00A5, 11'b011_0100_1010, 10);
`endif

    // Three consecutive loads while idle: sent back-to-back, in order.
    sent.delete();
    load = 1'b1; data_in = 32'h1111_1111;
    step();                                   // edge k
    data_in = 32'h2222_2222;
    step();
    data_in = 32'h3333_3333;
    step();
    load = 1'b0;
    chk("b2b_full", full, 1);
    n = 2;
    while (busy && n < 4 * WORD_CYC) begin
      step();
      n++;
    end
    chk("b2b_busy_len", n, 1 + 3 * WORD_CYC);
    chk("b2b_count", sent.size(), 3);
    chk("b2b_word0", sent[0], 32'h1111_1111);
    chk("b2b_word1", sent[1], 32'h2222_2222);
    chk("b2b_word2", sent[2], 32'h3333_3333);
    chk("b2b_overflow", overflow, 0);

    // Overflow on a full FIFO, clear pulse, then a load on the exact pop edge.
    sent.delete();
    step();
    load = 1'b1; data_in = 32'hA0A0_0001;
    step();                                   // edge k, idx 0
    data_in = 32'hB0B0_0002;
    step();                                   // idx 1: pop of word A
    data_in = 32'hC0C0_0003;
    step();                                   // idx 2: FIFO full
    data_in = 32'hDEAD_BEEF;
    step();                                   // idx 3: dropped
    load = 1'b0;
    chk("ovf_full", full, 1);
    chk("ovf_set", overflow, 1);
    overflow_clr = 1'b1;
    step();                                   // idx 4
    overflow_clr = 1'b0;
    chk("ovf_cleared", overflow, 0);
    idx = 4;
    while (idx < WORD_CYC) begin
      step();
      idx++;
    end
    chk("pre_pop_full", full, 1);
    load = 1'b1; data_in = 32'h5EED_0004;
    step();                                   // idx 161: pop and push together
    load = 1'b0;
    chk("pop_edge_full", full, 1);
    chk("pop_edge_overflow", overflow, 0);
    wait_idle(5 * WORD_CYC);
    seen_bad = 1'b0;
    foreach (sent[i]) if (sent[i] == 32'hDEAD_BEEF) seen_bad = 1'b1;
    chk("dropped_never_sent", seen_bad, 0);
    chk("ovf_seq_count", sent.size(), 4);
    chk("ovf_seq_word1", sent[1], 32'hB0B0_0002);
    chk("pop_edge_word_sent", sent[3], 32'h5EED_0004);

    // Asynchronous reset in the middle of the data bits of byte 2.
    step();
    load = 1'b1; data_in = 32'h00C3_5A7E;
    step();                                   // edge k
    load = 1'b0;
    repeat (1 + (2 * FB + 3) * CPB + 1) step();
    chk("mid_frame_busy", busy, 1);
    #2 Clear = 1'b0;
    #1;
    chk("async_tx", tx, 1);
    chk("async_busy", busy, 0);
    chk("async_full", full, 0);
    chk("async_overflow", overflow, 0);
    step();
    step();
    #2 Clear = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (i % 10 == 0) begin
        chk("post_reset_tx", tx, 1);
        chk("post_reset_busy", busy, 0);
      end
    end

    // Randomized traffic with an asynchronous reset in the middle.
    for (int i = 0; i < 6000; i++) begin
      w = $urandom;
      load = ($urandom_range(0, 99) < 2);
      data_in = w;
      overflow_clr = ($urandom_range(0, 99) < 3);
      if (i == 3000) begin
        #2 Clear = 1'b0;
        step();
        step();
        #2 Clear = 1'b1;
      end
      step();
    end
    load = 1'b0;
    overflow_clr = 1'b0;
    wait_idle(4 * WORD_CYC);
    chk("final_tx", tx, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
